// File: rtl/demux1_to_4_stream_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: lane count, select type
// and select decode.
package demux_pkg;

    localparam int unsigned LANES = 4;

    typedef logic [1:0] lane_sel_t;

    function automatic logic [LANES-1:0] sel_to_onehot(lane_sel_t sel);
        logic [LANES-1:0] onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/demux1_to_4_stream_if.sv
// Stream bundle between one producer, the demux and four lane consumers.
// Lane k data and count sit at [k*WIDTH +: WIDTH] and [k*CNT_W +: CNT_W].
interface demux1_to_4_stream_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) ();
    import demux_pkg::*;

    logic [WIDTH-1:0]       in_data;
    logic                   s1;
    logic                   s0;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       out_valid;
    logic [LANES-1:0]       out_ready;
    logic [LANES*CNT_W-1:0] beat_cnt;

    modport master (
        output in_data, s1, s0, in_valid, out_ready,
        input  in_ready, out_data, out_valid, beat_cnt
    );

    modport slave (
        input  in_data, s1, s0, in_valid, out_ready,
        output in_ready, out_data, out_valid, beat_cnt
    );

endinterface

// File: rtl/demux1_to_4_stream_lane.sv
// One output lane: a single registered holding slot with valid/ready handshake
// and a saturating count of accepted beats.
module demux_lane #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt,
    output logic             can_take
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (valid_q && rd_ready) begin
            valid_d = 1'b0;
        end
        // A write in the same cycle as a drain replaces the slot contents.
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid    = valid_q;
    assign data     = data_q;
    assign cnt      = cnt_q;
    assign can_take = !valid_q || rd_ready;

endmodule

// File: rtl/demux1_to_4_stream.sv
// Routes one input stream to one of four registered lanes chosen by {s1,s0};
// input readiness follows only the selected lane.
module demux1_to_4_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input logic                  clock,
    input logic                  reset_n,
    demux1_to_4_stream_if.slave  bus
);

    lane_sel_t        sel;
    logic [LANES-1:0] onehot;
    logic             in_ready;
    logic             accept;
    logic             wr_en      [LANES];
    logic             can_take   [LANES];
    logic             lane_valid [LANES];
    logic [WIDTH-1:0] lane_data  [LANES];
    logic [CNT_W-1:0] lane_cnt   [LANES];

    always_comb begin
        sel          = lane_sel_t'({bus.s1, bus.s0});
        onehot       = sel_to_onehot(sel);
        in_ready     = can_take[sel];
        accept       = bus.in_valid && in_ready;
        bus.in_ready = in_ready;
        for (int unsigned k = 0; k < LANES; k++) begin
            wr_en[k] = accept && onehot[k];
        end
    end

    always_comb begin
        bus.out_valid = '0;
        bus.out_data  = '0;
        bus.beat_cnt  = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            bus.out_valid[k]                = lane_valid[k];
            bus.out_data[k*WIDTH +: WIDTH]  = lane_data[k];
            bus.beat_cnt[k*CNT_W +: CNT_W]  = lane_cnt[k];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        demux_lane #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_lane (
            .clock    (clock),
            .reset_n  (reset_n),
            .wr_en    (wr_en[k]),
            .wr_data  (bus.in_data),
            .rd_ready (bus.out_ready[k]),
            .valid    (lane_valid[k]),
            .data     (lane_data[k]),
            .cnt      (lane_cnt[k]),
            .can_take (can_take[k])
        );
    end

endmodule

// File: tb/tb_demux1_to_4_stream.sv
// Directed bench for demux1_to_4_stream: an 8-bit-counter instance for routing and
// handshake scenarios, and a 4-bit-counter instance for saturation.
module tb_demux1_to_4_stream;

    logic clock;
    logic reset_n;
    int   pass_cnt;
    int   total_cnt;

    demux1_to_4_stream_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
    demux1_to_4_stream_if #(.WIDTH(8), .CNT_W(4)) bus4 ();

    demux1_to_4_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus8)
    );

    demux1_to_4_stream #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus8.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        #1;
        total_cnt++; if (bus8.out_valid !== 4'b0000) $display("FAIL reset_valid got=%b exp=%b", bus8.out_valid, 4'b0000); else pass_cnt++;
        total_cnt++; if (bus8.out_data !== 32'h0) $display("FAIL reset_data got=%h exp=%h", bus8.out_data, 32'h0); else pass_cnt++;
        total_cnt++; if (bus8.beat_cnt !== 32'h0) $display("FAIL reset_cnt got=%h exp=%h", bus8.beat_cnt, 32'h0); else pass_cnt++;
        total_cnt++; if (bus8.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=%b", bus8.in_ready, 1'b1); else pass_cnt++;
        total_cnt++; if (bus4.beat_cnt !== 16'h0) $display("FAIL reset_cnt4 got=%h exp=%h", bus4.beat_cnt, 16'h0); else pass_cnt++;
        step();
    endtask

    task automatic test_single();
        bus8.s1 = 1'b1; bus8.s0 = 1'b0; bus8.in_data = 8'hA5;
        bus8.in_valid = 1'b1; bus8.out_ready = 4'b0100;
        #1;
        total_cnt++; if (bus8.in_ready !== 1'b1) $display("FAIL single_in_ready got=%b exp=%b", bus8.in_ready, 1'b1); else pass_cnt++;
        step();
        bus8.in_valid = 1'b0;
        total_cnt++; if (bus8.out_valid !== 4'b0100) $display("FAIL single_valid got=%b exp=%b", bus8.out_valid, 4'b0100); else pass_cnt++;
        total_cnt++; if (bus8.out_data !== 32'h00A50000) $display("FAIL single_data got=%h exp=%h", bus8.out_data, 32'h00A50000); else pass_cnt++;
        total_cnt++; if (bus8.beat_cnt !== 32'h00010000) $display("FAIL single_cnt got=%h exp=%h", bus8.beat_cnt, 32'h00010000); else pass_cnt++;
        step();
        bus8.out_ready = 4'b0000;
        total_cnt++; if (bus8.out_valid !== 4'b0000) $display("FAIL single_drain_valid got=%b exp=%b", bus8.out_valid, 4'b0000); else pass_cnt++;
        total_cnt++; if (bus8.out_data[23:16] !== 8'hA5) $display("FAIL single_drain_hold got=%h exp=%h", bus8.out_data[23:16], 8'hA5); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        bus8.out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            d = 8'h11 * 8'(i + 1);
            {bus8.s1, bus8.s0} = 2'(i);
            bus8.in_data = d;
            bus8.in_valid = 1'b1;
            #1;
            total_cnt++; if (bus8.in_ready !== 1'b1) $display("FAIL b2b_in_ready lane=%0d got=%b exp=%b", i, bus8.in_ready, 1'b1); else pass_cnt++;
            step();
        end
        {bus8.s1, bus8.s0} = 2'b00;
        bus8.in_data = 8'h55;
        bus8.in_valid = 1'b1;
        #1;
        total_cnt++; if (bus8.in_ready !== 1'b0) $display("FAIL b2b_full_in_ready got=%b exp=%b", bus8.in_ready, 1'b0); else pass_cnt++;
        total_cnt++; if (bus8.out_valid !== 4'b1111) $display("FAIL b2b_valid got=%b exp=%b", bus8.out_valid, 4'b1111); else pass_cnt++;
        total_cnt++; if (bus8.out_data !== 32'h44332211) $display("FAIL b2b_data got=%h exp=%h", bus8.out_data, 32'h44332211); else pass_cnt++;
        step();
        bus8.in_valid = 1'b0;
        total_cnt++; if (bus8.out_data[7:0] !== 8'h11) $display("FAIL b2b_stall_hold got=%h exp=%h", bus8.out_data[7:0], 8'h11); else pass_cnt++;
        total_cnt++; if (bus8.beat_cnt !== 32'h01020101) $display("FAIL b2b_cnt got=%h exp=%h", bus8.beat_cnt, 32'h01020101); else pass_cnt++;
    endtask

    task automatic test_replace();
        {bus8.s1, bus8.s0} = 2'b01;
        bus8.in_data = 8'h5A;
        bus8.in_valid = 1'b1;
        bus8.out_ready = 4'b0010;
        #1;
        total_cnt++; if (bus8.in_ready !== 1'b1) $display("FAIL replace_in_ready got=%b exp=%b", bus8.in_ready, 1'b1); else pass_cnt++;
        step();
        bus8.in_valid = 1'b0;
        bus8.out_ready = 4'b0000;
        total_cnt++; if (bus8.out_valid !== 4'b1111) $display("FAIL replace_valid got=%b exp=%b", bus8.out_valid, 4'b1111); else pass_cnt++;
        total_cnt++; if (bus8.out_data !== 32'h44335A11) $display("FAIL replace_data got=%h exp=%h", bus8.out_data, 32'h44335A11); else pass_cnt++;
        total_cnt++; if (bus8.beat_cnt !== 32'h01020201) $display("FAIL replace_cnt got=%h exp=%h", bus8.beat_cnt, 32'h01020201); else pass_cnt++;
    endtask

    task automatic test_isolation();
        logic [7:0] d;
        bus8.out_ready = 4'b0000;
        do_reset();
        {bus8.s1, bus8.s0} = 2'b11;
        bus8.in_data = 8'h44;
        bus8.in_valid = 1'b1;
        step();
        bus8.out_ready = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            d = 8'h80 + 8'(i);
            {bus8.s1, bus8.s0} = 2'b00;
            bus8.in_data = d;
            bus8.in_valid = 1'b1;
            #1;
            total_cnt++; if (bus8.in_ready !== 1'b1) $display("FAIL iso_in_ready beat=%0d got=%b exp=%b", i, bus8.in_ready, 1'b1); else pass_cnt++;
            step();
            total_cnt++; if (bus8.out_data[7:0] !== d) $display("FAIL iso_lane0_data beat=%0d got=%h exp=%h", i, bus8.out_data[7:0], d); else pass_cnt++;
            total_cnt++; if (bus8.out_data[31:24] !== 8'h44) $display("FAIL iso_lane3_hold beat=%0d got=%h exp=%h", i, bus8.out_data[31:24], 8'h44); else pass_cnt++;
        end
        bus8.in_valid = 1'b0;
        total_cnt++; if (bus8.out_valid !== 4'b1001) $display("FAIL iso_valid got=%b exp=%b", bus8.out_valid, 4'b1001); else pass_cnt++;
        total_cnt++; if (bus8.beat_cnt !== 32'h0100000A) $display("FAIL iso_cnt got=%h exp=%h", bus8.beat_cnt, 32'h0100000A); else pass_cnt++;
        step();
        bus8.out_ready = 4'b0000;
        total_cnt++; if (bus8.out_valid !== 4'b1000) $display("FAIL iso_drain_valid got=%b exp=%b", bus8.out_valid, 4'b1000); else pass_cnt++;
    endtask

    task automatic test_saturation();
        {bus4.s1, bus4.s0} = 2'b10;
        bus4.out_ready = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            bus4.in_data = 8'(i);
            bus4.in_valid = 1'b1;
            #1;
            total_cnt++; if (bus4.in_ready !== 1'b1) $display("FAIL sat_in_ready beat=%0d got=%b exp=%b", i, bus4.in_ready, 1'b1); else pass_cnt++;
            step();
            if (i == 13) begin
                total_cnt++; if (bus4.beat_cnt[11:8] !== 4'd14) $display("FAIL sat_cnt14 got=%0d exp=%0d", bus4.beat_cnt[11:8], 14); else pass_cnt++;
            end
            if (i == 14) begin
                total_cnt++; if (bus4.beat_cnt[11:8] !== 4'd15) $display("FAIL sat_cnt15 got=%0d exp=%0d", bus4.beat_cnt[11:8], 15); else pass_cnt++;
            end
        end
        bus4.in_valid = 1'b0;
        total_cnt++; if (bus4.beat_cnt !== 16'h0F00) $display("FAIL sat_cnt_final got=%h exp=%h", bus4.beat_cnt, 16'h0F00); else pass_cnt++;
        total_cnt++; if (bus4.out_data[23:16] !== 8'd19) $display("FAIL sat_last_data got=%h exp=%h", bus4.out_data[23:16], 8'd19); else pass_cnt++;
        step();
        bus4.out_ready = 4'b0000;
    endtask

    task automatic test_reset_mid();
        bus8.out_ready = 4'b0000;
        {bus8.s1, bus8.s0} = 2'b00;
        bus8.in_data = 8'hC0;
        bus8.in_valid = 1'b1;
        step();
        {bus8.s1, bus8.s0} = 2'b10;
        bus8.in_data = 8'hC2;
        step();
        bus8.in_valid = 1'b0;
        total_cnt++; if (bus8.out_valid !== 4'b1101) $display("FAIL mid_pre_valid got=%b exp=%b", bus8.out_valid, 4'b1101); else pass_cnt++;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        total_cnt++; if (bus8.out_valid !== 4'b0000) $display("FAIL mid_rst_valid got=%b exp=%b", bus8.out_valid, 4'b0000); else pass_cnt++;
        total_cnt++; if (bus8.out_data !== 32'h0) $display("FAIL mid_rst_data got=%h exp=%h", bus8.out_data, 32'h0); else pass_cnt++;
        total_cnt++; if (bus8.beat_cnt !== 32'h0) $display("FAIL mid_rst_cnt got=%h exp=%h", bus8.beat_cnt, 32'h0); else pass_cnt++;
        {bus8.s1, bus8.s0} = 2'b01;
        bus8.in_data = 8'hD7;
        bus8.in_valid = 1'b1;
        #1;
        total_cnt++; if (bus8.in_ready !== 1'b1) $display("FAIL mid_post_in_ready got=%b exp=%b", bus8.in_ready, 1'b1); else pass_cnt++;
        step();
        bus8.in_valid = 1'b0;
        total_cnt++; if (bus8.out_valid !== 4'b0010) $display("FAIL mid_post_valid got=%b exp=%b", bus8.out_valid, 4'b0010); else pass_cnt++;
        total_cnt++; if (bus8.out_data !== 32'h0000D700) $display("FAIL mid_post_data got=%h exp=%h", bus8.out_data, 32'h0000D700); else pass_cnt++;
        total_cnt++; if (bus8.beat_cnt !== 32'h00000100) $display("FAIL mid_post_cnt got=%h exp=%h", bus8.beat_cnt, 32'h00000100); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset_n   = 1'b0;
        bus8.in_data = '0; bus8.s1 = 1'b0; bus8.s0 = 1'b0;
        bus8.in_valid = 1'b0; bus8.out_ready = '0;
        bus4.in_data = '0; bus4.s1 = 1'b0; bus4.s0 = 1'b0;
        bus4.in_valid = 1'b0; bus4.out_ready = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_replace();
        test_isolation();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
